// File: rtl/vec_dot_product.sv
// Signed fixed-point dot product of two SIZE-element vectors, COMBSIZE lanes per cycle.
// Define VEC_DOT_PRODUCT_SAT_EN to clamp y to the WIDTH-bit range and report it on sat.
module vec_dot_product #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int COMBSIZE = 4,
  parameter int FRAC     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH*SIZE-1:0]   a,
  input  logic [WIDTH*SIZE-1:0]   b,
  output logic [WIDTH-1:0]        y,
  output logic                    busy,
  output logic                    done,
  output logic                    sat
);

  localparam int N      = SIZE / COMBSIZE;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PROD_W = 2 * WIDTH;
  localparam int TERM_W = PROD_W - FRAC;
  localparam int ACC_W  = TERM_W + $clog2(SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (SIZE % COMBSIZE != 0) begin : g_bad_size
    $error("vec_dot_product: SIZE must be a multiple of COMBSIZE");
  end

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [WIDTH*SIZE-1:0]    a_q;
  logic [WIDTH*SIZE-1:0]    b_q;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  sum_next;
  logic signed [WIDTH-1:0]  ea;
  logic signed [WIDTH-1:0]  eb;
  logic signed [PROD_W-1:0] prod;
  logic signed [TERM_W-1:0] term;
  logic [WIDTH-1:0]         y_next;
  logic                     accept;
  logic                     last;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    busy    = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        busy = 1'b1;
        if (idx == LAST_IDX) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture: the block works from its own copy so a and b are free to
  // change once the request has been accepted.
  // ---------------------------------------------------------------------------
  // NOTE: the operand registers carry no reset; they are always written on the
  // accept edge before anything reads them, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane datapath: COMBSIZE products of the current element group, each
  // rescaled by dropping FRAC low bits (floor), summed at accumulator width.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: blocking assignments here are deliberate; lane_sum is a running
    // combinational total that each loop iteration must see updated.
    lane_sum = '0;
    ea       = '0;
    eb       = '0;
    prod     = '0;
    term     = '0;
    for (int l = 0; l < COMBSIZE; l++) begin
      ea       = a_q[(int'(idx) * COMBSIZE + l) * WIDTH +: WIDTH];
      eb       = b_q[(int'(idx) * COMBSIZE + l) * WIDTH +: WIDTH];
      prod     = PROD_W'(ea) * PROD_W'(eb);
      term     = prod[PROD_W-1:FRAC];
      lane_sum = lane_sum + ACC_W'(term);
    end
  end

  assign sum_next = acc + lane_sum;

  // ---------------------------------------------------------------------------
  // Result formatting
  // ---------------------------------------------------------------------------
`ifdef VEC_DOT_PRODUCT_SAT_EN
  localparam logic [WIDTH-1:0] Y_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Y_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [ACC_W-WIDTH:0] upper;
  logic                 clamp;
  logic                 sat_q;

  // The sum fits iff every bit from the WIDTH-1 sign position upward agrees.
  always_comb begin
    upper  = sum_next[ACC_W-1:WIDTH-1];
    y_next = sum_next[WIDTH-1:0];
    clamp  = 1'b0;
    if (!(&upper) && (|upper)) begin
      clamp  = 1'b1;
      y_next = sum_next[ACC_W-1] ? Y_MIN : Y_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    sat_q <= 1'b0;
    else if (last) sat_q <= clamp;
  end

  assign sat = sat_q;
`else
  assign y_next = sum_next[WIDTH-1:0];
  assign sat    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Accumulator, group index and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      idx  <= '0;
      y    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        acc <= '0;
        idx <= '0;
      end else if (busy) begin
        if (last) begin
          y    <= y_next;
          done <= 1'b1;
          acc  <= '0;
          idx  <= '0;
        end else begin
          acc <= sum_next;
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_dot_product.sv
// Directed self-checking bench for vec_dot_product at default parameters.
// Expected saturation results follow VEC_DOT_PRODUCT_SAT_EN as compiled.
module tb_vec_dot_product;

  localparam int WIDTH    = 32;
  localparam int SIZE     = 16;
  localparam int COMBSIZE = 4;
  localparam int FRAC     = 16;
  localparam int N        = SIZE / COMBSIZE;
  localparam int VW       = WIDTH * SIZE;

  localparam logic [WIDTH-1:0] ONE   = 32'h0001_0000;
  localparam logic [WIDTH-1:0] TWO   = 32'h0002_0000;
  localparam logic [WIDTH-1:0] BIG   = 32'h0040_0000;
  localparam logic [WIDTH-1:0] NBIG  = 32'hFFC0_0000;
  localparam logic [WIDTH-1:0] NEG15 = 32'hFFFE_8000;

`ifdef VEC_DOT_PRODUCT_SAT_EN
  localparam logic [WIDTH-1:0] Y_POS_OVF = 32'h7FFF_FFFF;
  localparam logic [WIDTH-1:0] Y_NEG_OVF = 32'h8000_0000;
  localparam logic             S_OVF     = 1'b1;
`else
  localparam logic [WIDTH-1:0] Y_POS_OVF = 32'h0000_0000;
  localparam logic [WIDTH-1:0] Y_NEG_OVF = 32'h0000_0000;
  localparam logic             S_OVF     = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [VW-1:0]    a     = '0;
  logic [VW-1:0]    b     = '0;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic             sat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vec_dot_product #(
    .WIDTH   (WIDTH),
    .SIZE    (SIZE),
    .COMBSIZE(COMBSIZE),
    .FRAC    (FRAC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .y    (y),
    .busy (busy),
    .done (done),
    .sat  (sat)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [WIDTH-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] single(input int pos, input logic [WIDTH-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    r[pos*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] ramp();
    logic [VW-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i*WIDTH +: WIDTH] = WIDTH'(i) << FRAC;
    return r;
  endfunction

  // Counts edges (sampled #1 after each) until done, bounded.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [VW-1:0] av, input logic [VW-1:0] bv,
                        input logic [WIDTH-1:0] ey, input logic es);
    int cnt;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    wait_done(cnt);
    check({tag, "_lat"},  cnt,  N);
    check({tag, "_y"},    y,    ey);
    check({tag, "_sat"},  sat,  es);
    check({tag, "_idle"}, busy, 1'b0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, done, 1'b0);
    check({tag, "_hold"},  y,    ey);
  endtask

  initial begin
    int cnt;
    int dones;
    logic [WIDTH-1:0] ycap;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_y",    y,    '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sat",  sat,  1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Basic function and arithmetic boundaries
    run_op("ones",   fill(ONE),          fill(TWO),          32'h0020_0000, 1'b0);
    run_op("neg",    single(0, NEG15),   single(0, TWO),     32'hFFFD_0000, 1'b0);
    run_op("floor",  single(0, 32'hFFFF_FFFF), single(0, 32'h0000_8000), 32'hFFFF_FFFF, 1'b0);
    run_op("last",   single(15, 32'h0003_0000), single(15, ONE), 32'h0003_0000, 1'b0);
    run_op("ramp",   ramp(),             fill(ONE),          32'h0078_0000, 1'b0);
    run_op("ovf",    fill(BIG),          fill(BIG),          Y_POS_OVF,     S_OVF);
    run_op("novf",   fill(BIG),          fill(NBIG),         Y_NEG_OVF,     S_OVF);
    run_op("clr",    fill(ONE),          fill(TWO),          32'h0020_0000, 1'b0);

    // Start while busy is ignored; operand changes after accept have no effect
    @(negedge clk);
    a = fill(ONE); b = fill(TWO); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk) a = fill(BIG);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    ycap  = '0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        ycap = y;
      end
    end
    check("ign_dones", dones, 1);
    check("ign_y",     ycap,  32'h0020_0000);

    // Reset mid-operation aborts without a done pulse
    @(negedge clk);
    a = fill(BIG); b = fill(BIG); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    check("abort_y",    y,    '0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clk) reset = 1'b1;
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_nodone", dones, 0);
    run_op("after_rst", single(0, NEG15), single(0, TWO), 32'hFFFD_0000, 1'b0);

    // Start held through done: back-to-back acceptance
    @(negedge clk);
    a = fill(ONE); b = fill(TWO); start = 1'b1;
    @(posedge clk); #1;
    wait_done(cnt);
    check("b2b_lat1", cnt, N);
    check("b2b_y1",   y,   32'h0020_0000);
    a = single(0, NEG15); b = single(0, TWO);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy",  busy, 1'b1);
    check("b2b_pulse", done, 1'b0);
    wait_done(cnt);
    check("b2b_lat2", cnt, N);
    check("b2b_y2",   y,   32'hFFFD_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
